// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: architectural widths and common index/data types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
// Latency: set/clear visible in busy_q next cycle; query outputs are combinational and
//          already fold in this cycle's clear and set, so callers need no extra terms.
// Backpressure: none; the caller turns the query outputs into a stall.
// Ports: clock/rst; set_en/set_idx (EX fire with rd_we); clr_en/clr_idx (writeback);
//        q_rs1/q_rs2 source queries -> rs1_busy/rs2_busy; q_rd -> rd_busy (WAW).
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic     clock,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t q_rs1,
  input  reg_idx_t q_rs2,
  input  reg_idx_t q_rd,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a same-index collision leaves the bit set:
  // the newly fired writer is still outstanding.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // A source is free in the writeback cycle because the value is bypassed,
  // but it is busy if its producer leaves the slot this very cycle.
  function automatic logic src_busy(input reg_idx_t rs);
    return (rs != '0) &&
           ((busy_q[rs] && !(clr_en && clr_idx == rs)) ||
            (set_en && set_idx == rs));
  endfunction

  // Destination check has no writeback exception: the older write must fully
  // retire before a younger writer to the same register may issue.
  always_comb begin
    rs1_busy = src_busy(q_rs1);
    rs2_busy = src_busy(q_rs2);
    rd_busy  = (q_rd != '0) && (busy_q[q_rd] || (set_en && set_idx == q_rd));
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: reads register file, bypasses writeback, zeroes x0,
// stalls RAW/WAW hazards via a scoreboard, and registers operands into one EX slot.
// Latency: 1 cycle ID handshake -> ex_valid; backpressure: id_ready drops while the slot
// is full and ex_ready is low, during a hazard, or during flush.
// Ports: id_* decode request; rf_ra*/rf_rd* register file read; wb_* writeback; ex_* slot.
module operand_fetch #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_imm,
  output logic [REG_ADDR_W-1:0] rf_ra1,
  output logic [REG_ADDR_W-1:0] rf_ra2,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_rs1_val,
  output logic [XLEN-1:0]       ex_rs2_val,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_rd_we
);

  import riscv_pkg::*;

  logic                  ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0]       ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0]       ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0]       ex_pc_q,      ex_pc_d;
  logic [XLEN-1:0]       ex_imm_q,     ex_imm_d;
  logic [REG_ADDR_W-1:0] ex_rd_q,      ex_rd_d;
  logic                  ex_rd_we_q,   ex_rd_we_d;

  logic ex_fire;
  logic id_fire;
  logic sb_set;
  logic rs1_busy, rs2_busy, rd_busy;
  logic hazard;
  logic [XLEN-1:0] rs1_sel, rs2_sel;

  assign rf_ra1 = id_rs1;
  assign rf_ra2 = id_rs2;

  // An instruction leaving the slot counts even during flush; only the held
  // (non-firing) one is dropped.
  assign ex_fire = ex_valid_q && ex_ready;
  assign sb_set  = ex_fire && ex_rd_we_q;

  reg_scoreboard u_sb (
    .clock    (clock),
    .rst      (rst),
    .set_en   (sb_set),
    .set_idx  (ex_rd_q),
    .clr_en   (wb_we),
    .clr_idx  (wb_rd),
    .q_rs1    (id_rs1),
    .q_rs2    (id_rs2),
    .q_rd     (id_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  assign hazard = id_valid && ((id_use_rs1 && rs1_busy) ||
                               (id_use_rs2 && rs2_busy) ||
                               (id_rd_we   && rd_busy));

  assign id_ready = !flush && !hazard && (!ex_valid_q || ex_ready);
  assign id_fire  = id_valid && id_ready;

  // x0 first, then same-cycle writeback bypass (register file returns the old value).
  function automatic logic [XLEN-1:0] pick(input logic [REG_ADDR_W-1:0] rs,
                                           input logic [XLEN-1:0]       rf_val);
    if (rs == '0)                 return '0;
    else if (wb_we && wb_rd == rs) return wb_data;
    else                          return rf_val;
  endfunction

  always_comb begin
    rs1_sel = pick(id_rs1, rf_rd1);
    rs2_sel = pick(id_rs2, rf_rd2);
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_we_d   = ex_rd_we_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (id_fire) begin
      ex_valid_d   = 1'b1;
      ex_rs1_val_d = rs1_sel;
      ex_rs2_val_d = rs2_sel;
      ex_pc_d      = id_pc;
      ex_imm_d     = id_imm;
      ex_rd_d      = id_rd;
      ex_rd_we_d   = id_rd_we;
    end else if (ex_fire) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_rd_we_q   <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_we_q   <= ex_rd_we_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_pc      = ex_pc_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rd_we   = ex_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, independent stream, RAW bypass, WAW,
// backpressure, flush and same-cycle scoreboard set/clear.
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_operand_fetch;

  logic        clock = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_rd_we;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_pc, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  operand_fetch #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clock      (clock),
    .rst        (rst),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_rd_we   (id_rd_we),
    .id_pc      (id_pc),
    .id_imm     (id_imm),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rd      (ex_rd),
    .ex_rd_we   (ex_rd_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] pc, input logic [31:0] imm);
    id_valid   = 1'b1;
    id_rs1     = rs1;
    id_use_rs1 = u1;
    id_rs2     = rs2;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_rd_we   = we;
    id_pc      = pc;
    id_imm     = imm;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    wb_we   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd_we = 1'b0;
    id_pc = '0; id_imm = '0;
    rf_rd1 = 32'hDEADBEEF; rf_rd2 = 32'hCAFEF00D;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ex_ready = 1'b1;

    // Reset
    tick(); tick();
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_rs1", ex_rs1_val, 32'd0);
    check("rst_busy", dut.u_sb.busy_q, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_id_ready", {31'd0, id_ready}, 32'd1);

    // Independent stream; x0 reads zero even with a writeback aimed at x0
    present(5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 32'h100, 32'd1);
    #1 check("s1_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    check("s1_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("s1_ex_rd", {27'd0, ex_rd}, 32'd1);
    check("s1_rs1_zero", ex_rs1_val, 32'd0);
    check("s1_ex_pc", ex_pc, 32'h100);
    present(5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 32'h104, 32'd2);
    wb(5'd0, 32'hFFFFFFFF);
    #1 check("s2_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    wb_we = 1'b0; id_valid = 1'b0;
    check("s2_ex_rd", {27'd0, ex_rd}, 32'd2);
    check("s2_rs1_x0", ex_rs1_val, 32'd0);
    check("s2_ex_imm", ex_imm, 32'd2);
    check("s2_busy", dut.u_sb.busy_q, 32'h2);
    tick();
    check("s2_drained", {31'd0, ex_valid}, 32'd0);
    check("s2_busy12", dut.u_sb.busy_q, 32'h6);
    wb(5'd1, 32'd0); tick();
    wb(5'd2, 32'd0); tick();
    wb_we = 1'b0;
    check("s_busy_clear", dut.u_sb.busy_q, 32'd0);

    // RAW: producer x5, consumer reads x5 (rs1) and x3 (rs2)
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h200, 32'd0);
    tick();
    present(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 32'h204, 32'd4);
    #1;
    check("raw_ra1", {27'd0, rf_ra1}, 32'd5);
    check("raw_ra2", {27'd0, rf_ra2}, 32'd3);
    check("raw_fire_stall", {31'd0, id_ready}, 32'd0);
    tick();
    check("raw_empty", {31'd0, ex_valid}, 32'd0);
    check("raw_busy5", dut.u_sb.busy_q, 32'h20);
    check("raw_stall1", {31'd0, id_ready}, 32'd0);
    tick();
    check("raw_stall2", {31'd0, id_ready}, 32'd0);
    wb(5'd5, 32'h1234);
    #1 check("raw_wb_accept", {31'd0, id_ready}, 32'd1);
    tick();
    wb_we = 1'b0; id_valid = 1'b0;
    check("raw_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("raw_bypass", ex_rs1_val, 32'h1234);
    check("raw_rs2_rf", ex_rs2_val, 32'hCAFEF00D);
    check("raw_ex_pc", ex_pc, 32'h204);
    check("raw_busy_clr", dut.u_sb.busy_q, 32'd0);
    tick();
    check("raw_busy6", dut.u_sb.busy_q, 32'h40);
    wb(5'd6, 32'd0); tick();
    wb_we = 1'b0;

    // WAW on x7
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h300, 32'd0);
    tick();
    id_valid = 1'b0;
    tick();
    check("waw_busy7", dut.u_sb.busy_q, 32'h80);
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h304, 32'd0);
    #1 check("waw_stall1", {31'd0, id_ready}, 32'd0);
    tick();
    check("waw_stall2", {31'd0, id_ready}, 32'd0);
    wb(5'd7, 32'd0);
    #1 check("waw_wb_cycle", {31'd0, id_ready}, 32'd0);
    tick();
    wb_we = 1'b0;
    #1 check("waw_accept", {31'd0, id_ready}, 32'd1);
    tick();
    id_valid = 1'b0;
    check("waw_ex_pc", ex_pc, 32'h304);
    check("waw_busy_free", dut.u_sb.busy_q, 32'd0);
    tick();
    check("waw_busy_reset", dut.u_sb.busy_q, 32'h80);
    wb(5'd7, 32'd0); tick();
    wb_we = 1'b0;

    // Backpressure
    ex_ready = 1'b0;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 32'h400, 32'h40);
    tick();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 32'h404, 32'h44);
    #1 check("bp_id_ready", {31'd0, id_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {31'd0, ex_valid}, 32'd1);
      check("bp_pc_hold", ex_pc, 32'h400);
      check("bp_imm_hold", ex_imm, 32'h40);
      check("bp_stall", {31'd0, id_ready}, 32'd0);
    end
    ex_ready = 1'b1;
    #1 check("bp_resume", {31'd0, id_ready}, 32'd1);
    tick();
    id_valid = 1'b0;
    check("bp_next_pc", ex_pc, 32'h404);
    check("bp_busy10", dut.u_sb.busy_q, 32'h400);
    tick();
    check("bp_empty", {31'd0, ex_valid}, 32'd0);
    check("bp_busy1011", dut.u_sb.busy_q, 32'hC00);
    wb(5'd10, 32'd0); tick();
    wb(5'd11, 32'd0); tick();
    wb_we = 1'b0;
    check("bp_busy_clear", dut.u_sb.busy_q, 32'd0);

    // Flush with a held instruction
    ex_ready = 1'b0;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h500, 32'd0);
    tick();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 32'h504, 32'd0);
    flush = 1'b1;
    #1 check("fl_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    check("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_busy", dut.u_sb.busy_q, 32'd0);
    ex_ready = 1'b1;
    tick();
    check("fl_no_accept", {31'd0, ex_valid}, 32'd0);

    // Same-cycle set and clear on x9
    ex_ready = 1'b0;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h600, 32'd0);
    tick();
    id_valid = 1'b0;
    ex_ready = 1'b1;
    wb(5'd9, 32'd0);
    tick();
    wb_we = 1'b0;
    check("sc_set_wins", dut.u_sb.busy_q, 32'h200);
    wb(5'd9, 32'd0); tick();
    wb_we = 1'b0;
    check("sc_drain", dut.u_sb.busy_q, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand stage of the single-core RV32I pipeline, and the read-side counterpart of `register_file`. It drives the register file's two read addresses, bypasses same-cycle writeback data, and forces x0 to zero. A pending-write scoreboard stalls RAW/WAW hazards, and decoded operands are registered into a valid/ready pipeline slot feeding execute.

## Interface

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width (32 architectural registers).

Ports:
- clock  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop held/incoming instruction (branch redirect).
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  instruction accepted this cycle when id_valid && id_ready.
- id_rs1, id_rs2  in  REG_ADDR_W  source indices.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- id_rd  in  REG_ADDR_W  destination index.
- id_rd_we  in  1  instruction writes rd.
- id_pc, id_imm  in  XLEN  passed through.
- rf_ra1, rf_ra2  out  REG_ADDR_W  register file read addresses; combinational copies of id_rs1/id_rs2.
- rf_rd1, rf_rd2  in  XLEN  register file read data (combinational, pre-write value).
- wb_we  in  1  writeback strobe (same signal as register file WE3).
- wb_rd  in  REG_ADDR_W  writeback index.
- wb_data  in  XLEN  writeback data.
- ex_valid  out  1  slot holds an instruction.
- ex_ready  in  1  execute accepts; must not depend combinationally on ex_valid.
- ex_rs1_val, ex_rs2_val, ex_pc, ex_imm  out  XLEN  registered operands.
- ex_rd  out  REG_ADDR_W  and  ex_rd_we  out  1  registered destination.

## Operation

- Output slot: a single register stage. Load occurs on the ID handshake; it empties when ex_valid && ex_ready with no new load.
- Operand select, per source s:
  - rs==0 gives 0.
  - Otherwise, wb_we && wb_rd==rs gives wb_data (bypass).
  - Otherwise rf_rdN.
- Scoreboard: busy[31:0], bit 0 hardwired 0.
  - Set busy[ex_rd] when the EX handshake fires with ex_rd_we && ex_rd!=0.
  - Clear busy[wb_rd] on wb_we.
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard when id_valid and any of:
  - id_use_rsN && rsN!=0 && busy[rsN] && !(wb_we && wb_rd==rsN).
  - id_use_rsN && rsN!=0 && an EX handshake fires this cycle with ex_rd_we && ex_rd==rsN.
  - id_rd_we && id_rd!=0 && (busy[id_rd] || firing ex_rd==id_rd) (WAW).
- id_ready = !flush && !hazard && (!ex_valid || ex_ready).
- flush:
  - Clears ex_valid next cycle. The held instruction is dropped and sets no busy bit.
  - No ID acceptance occurs that cycle.
  - An EX handshake in the same cycle still counts and sets busy.
- Downstream contract: every fired instruction with rd_we returns exactly one wb_we pulse, including killed ones, so busy always drains.
- Reset:
  - ex_valid=0, all ex_* data outputs 0, busy all 0.
  - id_ready follows its equation, so it is 1 when not flushing.

## Timing

- Latency: one cycle from ID handshake to ex_valid/operands.
- Throughput: one instruction per cycle absent hazards.
- Back-to-back dependent pair, producer P then consumer C:
  - C stalls from the cycle P fires until the cycle wb_we for P's rd is high.
  - C is accepted in that wb cycle using the bypassed wb_data.
- Stall with full slot: ex_* outputs hold stable while ex_valid && !ex_ready.
- rst has priority over flush and all handshakes. rst mid-stall empties the slot; that instruction is lost.
- rf_ra1/rf_ra2 are purely combinational, with zero-cycle read.

## Structure

- Shared package riscv_pkg holds:
  - XLEN, REG_ADDR_W, NUM_REGS=32.
  - typedefs word_t (logic [XLEN-1:0]) and reg_idx_t (logic [REG_ADDR_W-1:0]).
- One sub-module, reg_scoreboard:
  - Contains the busy vector, set/clear ports, and two source queries plus a destination query.
  - Its query outputs already include the wb-clear and EX-fire terms.
- Operand muxing, handshake, and the slot register stay in operand_fetch.

## Test plan

- Reset then independent stream: assert rst 2 cycles. Expect ex_valid=0 and busy=0. Then issue addi x1 rs1=x0 and addi x2 rs1=x0 with ex_ready=1 → both appear on consecutive cycles, rs1_val=0 even with rf_rd1=32'hDEADBEEF.
- RAW stall plus bypass: fire P with rd=x5, then present C with rs1=x5. Expect id_ready=0 until wb_we with wb_rd=5 and wb_data=32'h1234. C is accepted that cycle and ex_rs1_val=32'h1234.
- WAW: with P(rd=x7) outstanding, present C with rd=x7 and no sources. Expect a stall until P's writeback, then acceptance. busy[7] is set again when C fires.
- Backpressure: hold ex_ready=0 for 3 cycles with the slot full. Expect ex_* stable and id_ready=0, then draining resumes one per cycle.
- Flush: slot full (rd=x3, rd_we) with ex_ready=0; pulse flush. Expect ex_valid=0 next cycle, busy[3]=0, and no instruction accepted during the flush cycle.
- Same-cycle set/clear: EX fires rd=x9 while wb_we with wb_rd=9 (from an earlier killed instruction). Expect busy[9]=1 afterward.
